// File: rtl/bcd_modn_counter_if.sv
// bcd_modn_counter_if
//   Groups the control and data signals of one BCD counter stage so that a
//   stage can be passed around as a single port.
//
//   Signals (directions seen from the counter, i.e. the slave modport):
//     en        in   count-enable, one step per rising clock edge
//     up        in   direction, 1 = increment, 0 = decrement
//     load      in   synchronous parallel-load strobe
//     load_bcd  in   packed BCD value to load, digit 0 in [3:0]
//     bcd       out  registered packed BCD count, digit 0 in [3:0]
//     co        out  combinational carry/borrow for same-cycle cascade
//     err       out  one-cycle pulse flagging a rejected load
//
//   DIGITS must match the DIGITS of the counter the interface is bound to.

interface bcd_modn_counter_if #(
  parameter int DIGITS = 2
);

  logic                  en;
  logic                  up;
  logic                  load;
  logic [4*DIGITS-1:0]   load_bcd;
  logic [4*DIGITS-1:0]   bcd;
  logic                  co;
  logic                  err;

  // Driver side: whoever steers the counter (testbench, lower cascade stage).
  modport master (
    output en,
    output up,
    output load,
    output load_bcd,
    input  bcd,
    input  co,
    input  err
  );

  // Counter side.
  modport slave (
    input  en,
    input  up,
    input  load,
    input  load_bcd,
    output bcd,
    output co,
    output err
  );

endinterface

// File: rtl/bcd_modn_counter.sv
// bcd_modn_counter
//   Synchronous up/down BCD counter with any number of digits and any
//   modulus up to 10^DIGITS. Stages are chained by driving the next stage's
//   en from this stage's co, so a whole clock (seconds/minutes/hours)
//   advances on a single edge.
//
//   Ports:
//     CLK   in   sole clock, all state changes on its rising edge
//     RST   in   synchronous active-high reset (bcd = 0, err = 0)
//     bus   slave modport of bcd_modn_counter_if carrying en, up, load,
//           load_bcd, bcd, co and err
//
//   Edge priority: RST, then load, then en, then hold.

module bcd_modn_counter #(
  parameter int          DIGITS  = 2,
  parameter int unsigned MODULUS = 60
) (
  input  logic              CLK,
  input  logic              RST,
  bcd_modn_counter_if.slave bus
);

  localparam int W = 4 * DIGITS;

  // 10^n for elaboration-time range checks. Only evaluated for n <= 8 in
  // legal configurations, so 32 bits are enough.
  function automatic int unsigned pow10(input int n);
    int unsigned r;
    r = 1;
    for (int i = 0; i < n && i < 9; i++) begin
      r = r * 10;
    end
    return r;
  endfunction

  // Integer to packed BCD, used once to build the terminal count.
  function automatic logic [W-1:0] to_bcd(input int unsigned v);
    logic [W-1:0] r;
    int unsigned  x;
    r = '0;
    x = v;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x           = x / 10;
    end
    return r;
  endfunction

  // Illegal parameter combinations stop elaboration.
  if (DIGITS < 1 || DIGITS > 8) begin : g_bad_digits
    $error("bcd_modn_counter: DIGITS=%0d outside 1..8", DIGITS);
  end else if (MODULUS < 2 || MODULUS > pow10(DIGITS)) begin : g_bad_modulus
    $error("bcd_modn_counter: MODULUS=%0d outside 2..10^%0d", MODULUS, DIGITS);
  end

  // Terminal count MODULUS-1 in BCD. Packed BCD with valid digits orders the
  // same way as plain unsigned binary, so range checks below are simple
  // unsigned compares against this constant with no decimal conversion.
  localparam logic [W-1:0] MAX_BCD    = to_bcd(MODULUS - 1);
  localparam bit           FULL_RANGE = (MODULUS == pow10(DIGITS));

  logic [W-1:0] bcd_q, bcd_d;
  logic         err_q, err_d;

  logic [W-1:0] inc_val, dec_val;
  logic         carry, borrow;
  logic         load_digits_ok, state_digits_ok, all_nines;
  logic         load_ok, state_ok;
  logic         at_max, at_zero;

  // Per-digit ripple increment and decrement of the current count. A digit
  // only changes if every lower digit overflowed (9 -> 0) or underflowed
  // (0 -> 9); the ripple settles within one cycle.
  always_comb begin
    inc_val = bcd_q;
    dec_val = bcd_q;
    carry   = 1'b1;
    borrow  = 1'b1;
    for (int d = 0; d < DIGITS; d++) begin
      if (carry) begin
        inc_val[4*d +: 4] = (bcd_q[4*d +: 4] == 4'd9) ? 4'd0 : bcd_q[4*d +: 4] + 4'd1;
      end
      if (borrow) begin
        dec_val[4*d +: 4] = (bcd_q[4*d +: 4] == 4'd0) ? 4'd9 : bcd_q[4*d +: 4] - 4'd1;
      end
      carry  = carry  & (bcd_q[4*d +: 4] == 4'd9);
      borrow = borrow & (bcd_q[4*d +: 4] == 4'd0);
    end
  end

  // Digit-level sanity of the load value and of the current state, plus the
  // all-nines detector used when the modulus spans the full digit range.
  always_comb begin
    load_digits_ok  = 1'b1;
    state_digits_ok = 1'b1;
    all_nines       = 1'b1;
    for (int d = 0; d < DIGITS; d++) begin
      if (bus.load_bcd[4*d +: 4] > 4'd9) begin
        load_digits_ok = 1'b0;
      end
      if (bcd_q[4*d +: 4] > 4'd9) begin
        state_digits_ok = 1'b0;
      end
      if (bcd_q[4*d +: 4] != 4'd9) begin
        all_nines = 1'b0;
      end
    end
  end

  // Wrap detection. For a full-range modulus the terminal count is all 9s,
  // so the digit detector replaces the constant compare. Both at_max and
  // at_zero imply an in-range state, which keeps co low on a corrupt value.
  always_comb begin
    load_ok  = load_digits_ok  && (bus.load_bcd <= MAX_BCD);
    state_ok = state_digits_ok && (bcd_q <= MAX_BCD);
    at_max   = FULL_RANGE ? all_nines : (bcd_q == MAX_BCD);
    at_zero  = (bcd_q == '0);
  end

  // Next-state selection below reset: load beats count, count beats hold.
  // A corrupt (out-of-range) count is cleared on the next enabled edge.
  always_comb begin
    bcd_d = bcd_q;
    err_d = 1'b0;
    if (bus.load) begin
      if (load_ok) begin
        bcd_d = bus.load_bcd;
      end else begin
        err_d = 1'b1;
      end
    end else if (bus.en) begin
      if (!state_ok) begin
        bcd_d = '0;
      end else if (bus.up) begin
        bcd_d = at_max ? '0 : inc_val;
      end else begin
        bcd_d = at_zero ? MAX_BCD : dec_val;
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      bcd_q <= '0;
      err_q <= 1'b0;
    end else begin
      bcd_q <= bcd_d;
      err_q <= err_d;
    end
  end

  // co is deliberately unregistered so a chained stage steps on the same
  // edge as the one that wraps this stage.
  assign bus.co  = bus.en & ~bus.load & ~RST & (bus.up ? at_max : at_zero);
  assign bus.bcd = bcd_q;
  assign bus.err = err_q;

endmodule

// File: tb/tb_bcd_modn_counter.sv
// tb_bcd_modn_counter
//   Directed bench for bcd_modn_counter. Three stages share one clock/reset:
//     dutMin   DIGITS=2, MODULUS=60   (minute stage)
//     dutHour  DIGITS=2, MODULUS=24   (hour stage, en can follow dutMin.co)
//     dutWide  DIGITS=3, MODULUS=1000 (full-range width corner)

module tb_bcd_modn_counter;

  logic CLK;
  logic RST;
  logic cascadeMode;
  logic hourEnTb;

  int vectorCount;
  int missCount;

  bcd_modn_counter_if #(.DIGITS(2)) minIf ();
  bcd_modn_counter_if #(.DIGITS(2)) hourIf ();
  bcd_modn_counter_if #(.DIGITS(3)) wideIf ();

  bcd_modn_counter #(.DIGITS(2), .MODULUS(60)) dutMin (
    .CLK (CLK),
    .RST (RST),
    .bus (minIf.slave)
  );

  bcd_modn_counter #(.DIGITS(2), .MODULUS(24)) dutHour (
    .CLK (CLK),
    .RST (RST),
    .bus (hourIf.slave)
  );

  bcd_modn_counter #(.DIGITS(3), .MODULUS(1000)) dutWide (
    .CLK (CLK),
    .RST (RST),
    .bus (wideIf.slave)
  );

  // The hour stage is either steered directly or chained off the minutes.
  assign hourIf.en = cascadeMode ? minIf.co : hourEnTb;

  // 100 MHz free-running clock.
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // One comparison: count it, report it if it disagrees.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectorCount++;
    if (got !== exp) begin
      missCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drive the minute stage inputs.
  task automatic applyStimulus(input logic en, input logic up, input logic load, input logic [7:0] loadBcd);
    minIf.en       = en;
    minIf.up       = up;
    minIf.load     = load;
    minIf.load_bcd = loadBcd;
  endtask

  // Advance to just after the next rising edge.
  task automatic stepClk();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    logic [7:0] expMin;
    logic [7:0] badLoads [3];

    vectorCount = 0;
    missCount   = 0;
    badLoads[0] = 8'h3A;
    badLoads[1] = 8'h60;
    badLoads[2] = 8'h1F;

    cascadeMode     = 1'b0;
    hourEnTb        = 1'b0;
    hourIf.up       = 1'b1;
    hourIf.load     = 1'b0;
    hourIf.load_bcd = 8'h00;
    wideIf.en       = 1'b0;
    wideIf.up       = 1'b1;
    wideIf.load     = 1'b0;
    wideIf.load_bcd = 12'h000;

    // Reset, with a down-count request at zero that must not raise co.
    RST = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
    stepClk();
    stepClk();
    checkOutput("reset_bcd", 32'(minIf.bcd), 32'h00);
    checkOutput("reset_err", 32'(minIf.err), 32'h0);
    checkOutput("reset_co", 32'(minIf.co), 32'h0);
    checkOutput("reset_hour_bcd", 32'(hourIf.bcd), 32'h00);
    checkOutput("reset_wide_bcd", 32'(wideIf.bcd), 32'h000);

    // Minute wrap: 60 enabled edges walk 00..59 and back to 00.
    RST = 1'b0;
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 60; i++) begin
      #1;
      expMin = {4'(i / 10), 4'(i % 10)};
      checkOutput("min_up_bcd", 32'(minIf.bcd), 32'(expMin));
      checkOutput("min_up_co", 32'(minIf.co), 32'(i == 59));
      stepClk();
    end
    checkOutput("min_wrap_bcd", 32'(minIf.bcd), 32'h00);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);

    // Down wrap on the hour stage: 00 -> 23, then borrow 20 -> 19.
    hourIf.up = 1'b0;
    hourEnTb  = 1'b1;
    #1;
    checkOutput("hour_down_co", 32'(hourIf.co), 32'h1);
    stepClk();
    checkOutput("hour_down_wrap", 32'(hourIf.bcd), 32'h23);
    hourEnTb        = 1'b0;
    hourIf.load     = 1'b1;
    hourIf.load_bcd = 8'h20;
    stepClk();
    checkOutput("hour_load20", 32'(hourIf.bcd), 32'h20);
    hourIf.load = 1'b0;
    hourEnTb    = 1'b1;
    #1;
    checkOutput("hour_borrow_co", 32'(hourIf.co), 32'h0);
    stepClk();
    checkOutput("hour_borrow", 32'(hourIf.bcd), 32'h19);
    hourEnTb = 1'b0;

    // Loads: one good value, then three rejected ones.
    applyStimulus(1'b0, 1'b1, 1'b1, 8'h45);
    stepClk();
    checkOutput("load45_bcd", 32'(minIf.bcd), 32'h45);
    checkOutput("load45_err", 32'(minIf.err), 32'h0);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b0, 1'b1, 1'b1, badLoads[k]);
      stepClk();
      checkOutput("badload_bcd", 32'(minIf.bcd), 32'h45);
      checkOutput("badload_err", 32'(minIf.err), 32'h1);
      applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
      stepClk();
      checkOutput("badload_err_drop", 32'(minIf.err), 32'h0);
    end

    // Priority: load beats en even at the terminal count.
    applyStimulus(1'b0, 1'b1, 1'b1, 8'h59);
    stepClk();
    applyStimulus(1'b1, 1'b1, 1'b1, 8'h30);
    #1;
    checkOutput("prio_load_co", 32'(minIf.co), 32'h0);
    stepClk();
    checkOutput("prio_load_bcd", 32'(minIf.bcd), 32'h30);

    // Priority: reset beats load and en.
    applyStimulus(1'b0, 1'b1, 1'b1, 8'h59);
    stepClk();
    RST = 1'b1;
    applyStimulus(1'b1, 1'b1, 1'b1, 8'h12);
    #1;
    checkOutput("prio_rst_co", 32'(minIf.co), 32'h0);
    stepClk();
    checkOutput("prio_rst_bcd", 32'(minIf.bcd), 32'h00);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
    #1;
    checkOutput("rst_masks_co", 32'(minIf.co), 32'h0);
    stepClk();
    RST = 1'b0;

    // Cascade 23:59 -> 00:00 on one edge.
    applyStimulus(1'b0, 1'b1, 1'b1, 8'h59);
    hourIf.up       = 1'b1;
    hourIf.load     = 1'b1;
    hourIf.load_bcd = 8'h23;
    stepClk();
    hourIf.load = 1'b0;
    cascadeMode = 1'b1;
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h00);
    #1;
    checkOutput("casc_min_co", 32'(minIf.co), 32'h1);
    checkOutput("casc_hour_co", 32'(hourIf.co), 32'h1);
    stepClk();
    checkOutput("casc_min_bcd", 32'(minIf.bcd), 32'h00);
    checkOutput("casc_hour_bcd", 32'(hourIf.bcd), 32'h00);
    checkOutput("casc_hour_co_after", 32'(hourIf.co), 32'h0);
    stepClk();
    checkOutput("casc_min_next", 32'(minIf.bcd), 32'h01);
    checkOutput("casc_hour_hold", 32'(hourIf.bcd), 32'h00);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
    cascadeMode = 1'b0;

    // Width corner: 998 -> 999 -> 000 -> 001, then 000 -> 999 downward.
    wideIf.load     = 1'b1;
    wideIf.load_bcd = 12'h998;
    stepClk();
    wideIf.load = 1'b0;
    wideIf.en   = 1'b1;
    wideIf.up   = 1'b1;
    #1;
    checkOutput("wide_co_998", 32'(wideIf.co), 32'h0);
    stepClk();
    checkOutput("wide_999", 32'(wideIf.bcd), 32'h999);
    checkOutput("wide_co_999", 32'(wideIf.co), 32'h1);
    stepClk();
    checkOutput("wide_000", 32'(wideIf.bcd), 32'h000);
    checkOutput("wide_co_000", 32'(wideIf.co), 32'h0);
    stepClk();
    checkOutput("wide_001", 32'(wideIf.bcd), 32'h001);
    wideIf.en       = 1'b0;
    wideIf.load     = 1'b1;
    wideIf.load_bcd = 12'h9A0;
    stepClk();
    checkOutput("wide_badload_bcd", 32'(wideIf.bcd), 32'h001);
    checkOutput("wide_badload_err", 32'(wideIf.err), 32'h1);
    wideIf.load_bcd = 12'h000;
    stepClk();
    wideIf.load = 1'b0;
    wideIf.en   = 1'b1;
    wideIf.up   = 1'b0;
    #1;
    checkOutput("wide_down_co", 32'(wideIf.co), 32'h1);
    stepClk();
    checkOutput("wide_down_wrap", 32'(wideIf.bcd), 32'h999);
    wideIf.en = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule
